// File: rtl/raddr_gen_mc_pkg.sv
// Shared types and helpers for the multi-channel read-address generator.
package raddr_gen_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } rg_state_e;

  // Heads beyond the line length mean "line fully written"; saturate at num.
  function automatic logic [31:0] clamp_head(input logic [31:0] h, input logic [31:0] num);
    return (h > num) ? num : h;
  endfunction

  // Unsigned minimum of two values.
  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/raddr_gen_mc_head_min.sv
// Masked minimum over the write heads (with clamp) plus "any enabled head still open".
module raddr_head_min
  import raddr_gen_pkg::*;
#(
  parameter int CH  = 2,
  parameter int AW  = 11,
  parameter int NUM = 1280
) (
  input  logic [CH*AW-1:0] head_i,
  input  logic [CH-1:0]    ch_en_i,
  output logic [AW-1:0]    lim_o,
  output logic             any_open_o
);

  logic [AW-1:0] hc;
  logic          found;

  // Walk the channels; a disabled mask yields lim=0 so nothing is issued.
  always_comb begin
    lim_o      = '0;
    any_open_o = 1'b0;
    found      = 1'b0;
    hc         = '0;
    for (int i = 0; i < CH; i++) begin
      hc = AW'(clamp_head(32'(head_i[i*AW +: AW]), 32'(NUM)));
      if (ch_en_i[i]) begin
        lim_o = found ? AW'(min_u(32'(lim_o), 32'(hc))) : hc;
        found = 1'b1;
        if (hc != AW'(NUM)) any_open_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/raddr_gen_mc.sv
// Line-buffer read-address generator: one sweep 0..NUM-1 per line, never
// overtaking the slowest enabled write head, with ready/valid backpressure.
// Optional statistics counters are enabled by defining RADDR_GEN_MC_STAT_EN.
module raddr_gen_mc
  import raddr_gen_pkg::*;
#(
  parameter  int NUM   = 1280,
  parameter  int CH    = 2,
  parameter  int LINES = 720,
  localparam int AW    = $clog2(NUM+1),
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sof,
  input  logic [CH*AW-1:0] head,
  input  logic [CH-1:0]    ch_en,
  input  logic             rd_ready,
  output logic [AW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic             rd_sol,
  output logic             rd_eol,
  output logic             finish,
  output logic             frame_done,
`ifdef RADDR_GEN_MC_STAT_EN
  output logic [15:0]      starve_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic [LW-1:0]    line_cnt
);

  rg_state_e     state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d, sol_q, sol_d, eol_q, eol_d;
  logic          fin_q, fin_d, fd_q, fd_d;
  logic [LW-1:0] line_q, line_d;

  logic [AW-1:0] lim;
  logic          any_open;
  logic          slot, hs, issue;

  raddr_head_min #(.CH(CH), .AW(AW), .NUM(NUM)) u_hmin (
    .head_i    (head),
    .ch_en_i   (ch_en),
    .lim_o     (lim),
    .any_open_o(any_open)
  );

  // Output register is free when empty or being drained this cycle.
  assign slot  = !vld_q || rd_ready;
  assign hs    = vld_q && rd_ready;
  assign issue = (state_q == RUN) && slot && (cur_q < AW'(NUM)) && (cur_q < lim);

  // Next-state: sof overrides everything; a stalled beat holds all rd_* fields.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    sol_d   = sol_q;
    eol_d   = eol_q;
    line_d  = line_q;
    fin_d   = 1'b0;
    fd_d    = 1'b0;
    if (sof) begin
      cur_d   = '0;
      vld_d   = 1'b0;
      line_d  = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hs && eol_q) begin
            fin_d   = 1'b1;
            state_d = WAIT;
            if (line_q == LW'(LINES-1)) begin
              line_d = '0;
              fd_d   = 1'b1;
            end else begin
              line_d = line_q + LW'(1);
            end
          end
          if (issue) begin
            addr_d = cur_q;
            vld_d  = 1'b1;
            sol_d  = (cur_q == '0);
            eol_d  = (cur_q == AW'(NUM-1));
            cur_d  = cur_q + AW'(1);
          end else if (slot) begin
            vld_d = 1'b0;
          end
        end
        WAIT: begin
          vld_d = 1'b0;
          // Rearm once some enabled writer has started the next line.
          if (any_open) begin
            cur_d   = '0;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cur_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      fin_q   <= 1'b0;
      fd_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      sol_q   <= sol_d;
      eol_q   <= eol_d;
      fin_q   <= fin_d;
      fd_q    <= fd_d;
      line_q  <= line_d;
    end
  end

  assign rd_addr    = addr_q;
  assign rd_valid   = vld_q;
  assign rd_sol     = sol_q;
  assign rd_eol     = eol_q;
  assign finish     = fin_q;
  assign frame_done = fd_q;
  assign line_cnt   = line_q;

`ifdef RADDR_GEN_MC_STAT_EN
  logic [15:0] starve_q, stall_q;
  logic        starve_inc, stall_inc;

  assign starve_inc = (state_q == RUN) && slot && !(cur_q < lim);
  assign stall_inc  = vld_q && !rd_ready;

  // Saturating event counters, cleared at start of frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
      stall_q  <= '0;
    end else if (sof) begin
      starve_q <= '0;
      stall_q  <= '0;
    end else begin
      if (starve_inc && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
      if (stall_inc  && stall_q  != 16'hFFFF) stall_q  <= stall_q  + 16'd1;
    end
  end

  assign starve_cnt = starve_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_raddr_gen_mc.sv
// Randomized bench for raddr_gen_mc against a cycle-level behavioural model.
module tb_raddr_gen_mc;
  localparam int NUM   = 8;
  localparam int CH    = 2;
  localparam int LINES = 3;
  localparam int AW    = $clog2(NUM+1);
  localparam int LW    = $clog2(LINES);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             sof = 1'b0;
  logic             rd_ready = 1'b0;
  logic [CH*AW-1:0] head = '0;
  logic [CH-1:0]    ch_en = '1;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid, rd_sol, rd_eol, finish, frame_done;
  logic [LW-1:0]    line_cnt;
`ifdef RADDR_GEN_MC_STAT_EN
  logic [15:0]      starve_cnt, stall_cnt;
`endif

  raddr_gen_mc #(.NUM(NUM), .CH(CH), .LINES(LINES)) dut (
    .clk(clk), .rstn(rstn), .sof(sof), .head(head), .ch_en(ch_en),
    .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_sol(rd_sol), .rd_eol(rd_eol), .finish(finish), .frame_done(frame_done),
`ifdef RADDR_GEN_MC_STAT_EN
    .starve_cnt(starve_cnt), .stall_cnt(stall_cnt),
`endif
    .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int hv[CH];

  // Model: what the downstream should see, tracked as "beats issued this line".
  bit m_valid, m_sol, m_eol, m_fin, m_fd, m_done;
  int m_addr, m_next, m_line;
  int obs_beats;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lim_of();
    int m = -1;
    for (int i = 0; i < CH; i++)
      if (ch_en[i]) begin
        int h = (hv[i] > NUM) ? NUM : hv[i];
        if (m < 0 || h < m) m = h;
      end
    return (m < 0) ? 0 : m;
  endfunction

  function automatic bit open_of();
    for (int i = 0; i < CH; i++)
      if (ch_en[i] && hv[i] < NUM) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sol = 0; m_eol = 0; m_fin = 0; m_fd = 0; m_done = 0;
    m_addr = 0; m_next = 0; m_line = 0; obs_beats = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int  lim  = lim_of();
    bit  free = !m_valid || rd_ready;
    bit  took = m_valid && rd_ready;
    bit  fin  = 0, fd = 0;
    if (sof) begin
      m_next = 0; m_valid = 0; m_line = 0; m_done = 0;
    end else if (!m_done) begin
      if (took && m_eol) begin
        fin = 1;
        fd = (m_line == LINES-1);
        m_line = (m_line + 1) % LINES;
        m_done = 1;
      end
      if (free && m_next < NUM && m_next < lim) begin
        m_addr = m_next; m_valid = 1;
        m_sol = (m_next == 0); m_eol = (m_next == NUM-1);
        m_next++;
      end else if (free) begin
        m_valid = 0;
      end
    end else if (open_of()) begin
      m_next = 0; m_done = 0;
    end
    m_fin = fin; m_fd = fd;
  endtask

  task automatic check_outs();
    chk("rd_valid", rd_valid, m_valid);
    if (m_valid) begin
      chk("rd_addr", rd_addr, m_addr);
      chk("rd_sol", rd_sol, m_sol);
      chk("rd_eol", rd_eol, m_eol);
    end
    chk("finish", finish, m_fin);
    chk("frame_done", frame_done, m_fd);
    chk("line_cnt", line_cnt, m_line);
  endtask

  task automatic tick();
    bit was_sof;
    for (int i = 0; i < CH; i++) head[i*AW +: AW] = AW'(hv[i]);
    @(negedge clk);
    was_sof = sof;
    // Accepted beats of a line must come out as 0,1,2,... with no gaps or repeats.
    if (rd_valid && rd_ready) begin
      chk("seq_addr", rd_addr, obs_beats);
      obs_beats++;
    end
    model_step();
    @(posedge clk);
    #1;
    check_outs();
    if (finish) begin
      chk("beats_per_line", obs_beats, NUM);
      obs_beats = 0;
    end
    if (was_sof) obs_beats = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_sol"}, rd_sol, 0);
    chk({tag, "_eol"}, rd_eol, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_line_cnt"}, line_cnt, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < CH; i++) hv[i] = 0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Full-rate sweep with both heads complete.
    hv = '{default: NUM}; rd_ready = 1'b1;
    repeat (12) tick();

    // Rearm, then head1 holds at 3 before completing.
    hv = '{default: 0}; tick();
    hv[0] = NUM; hv[1] = 3;
    repeat (6) tick();
    hv[1] = NUM;
    repeat (8) tick();

    // Backpressure with ready toggling every cycle.
    hv = '{default: 0}; tick();
    hv = '{default: NUM};
    for (int c = 0; c < 22; c++) begin
      rd_ready = (c % 2) == 0;
      tick();
    end
    rd_ready = 1'b1;

    // Only channel 0 gates reading; channel 1 idle at 0.
    hv = '{default: 0}; tick();
    ch_en = 2'b01; hv[0] = NUM; hv[1] = 0;
    repeat (12) tick();

    // No channel enabled: nothing may be issued.
    hv[0] = 0; tick();
    ch_en = '0; hv = '{default: NUM};
    repeat (6) tick();

    // sof in the middle of a line.
    ch_en = '1;
    repeat (6) tick();
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (12) tick();

    // Asynchronous reset in the middle of a line.
    hv = '{default: 0}; tick();
    hv = '{default: NUM};
    repeat (4) tick();
    do_reset();
    repeat (12) tick();

    // Random heads (including values above NUM), ready, masks and occasional sof.
    for (int n = 0; n < 2000; n++) begin
      rd_ready = $urandom_range(0, 3) != 0;
      sof      = $urandom_range(0, 199) == 0;
      ch_en    = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '1;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 3) == 0) hv[i] = $urandom_range(0, (1 << AW) - 1);
      tick();
      if (n == 1000) do_reset();
    end
    sof = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
